servo_pwm_gen: RTL and testbench
================================

Name: servo_pwm_gen

Overview:
Consumes the slew-limited duty value from the microstepping stage and generates the 50 Hz servo PWM waveform for one axis. Duty is in 10 us units, so 150 gives a 1.5 ms pulse. The duty is clamped to safe mechanical limits and latched only at frame boundaries, so the output never produces runt or stretched pulses. The block sits directly downstream of microstepping and drives the servo pin.

Parameters:
FRAME_CYCLES, 240000, clocks per PWM frame (20 ms at 12 MHz)
TICK_CYCLES, 120, clocks per duty LSB (10 us at 12 MHz)
DUTY_MIN, 8'd100, lowest legal duty (1.0 ms)
DUTY_MAX, 8'd200, highest legal duty (2.0 ms)
DUTY_RESET, 8'd150, duty_latched value held in reset (neutral)

Ports:
clk_12mhz  input  1  system clock, 12 MHz
reset  input  1  asynchronous, active-high reset
enable  input  1  run PWM frames while high
duty  input  8  target duty from microstepping (actual_duty_x)
pwm_out  output  1  servo drive pin, registered
frame_start  output  1  one-clock strobe on the first clock of each frame
duty_latched  output  8  clamped duty in effect for the current frame
clamped  output  1  high for the whole frame if that frame's duty was clamped

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-pulse):
  - state = IDLE, frame_ctr = 0.
  - pwm_out = 0, frame_start = 0, clamped = 0.
  - duty_latched = DUTY_RESET.
- States are IDLE, HIGH and LOW. pwm_out is 1 only in HIGH, and is driven from a register.
- frame_ctr is 18 bits and counts 0..FRAME_CYCLES-1.
- Pulse length is high_cycles = duty_latched * TICK_CYCLES, computed at 18-bit width. At the defaults, 255*120 = 30600, so no overflow is possible.
- IDLE:
  - pwm_out = 0.
  - enable sampled high: on the next clock, frame_ctr = 0, state = HIGH, duty_latched and clamped are loaded, and frame_start = 1.
  - This gives 1-clock latency from enable to the first high cycle.
- Frame boundary latch:
  - duty_latched = DUTY_MIN if duty < DUTY_MIN; DUTY_MAX if duty > DUTY_MAX; otherwise duty.
  - clamped = 1 if either limit applied, else 0.
  - Values of duty sampled at any other time are ignored; a mid-frame change takes effect from the next frame.
- HIGH:
  - Lasts exactly high_cycles clocks, frame_ctr 0..high_cycles-1.
  - When frame_ctr == high_cycles-1, the next state is LOW.
- LOW:
  - Runs until frame_ctr == FRAME_CYCLES-1.
  - On that clock, the next state is HIGH (with a new latch, frame_start = 1 and frame_ctr = 0) if enable = 1; otherwise IDLE.
  - Frame period is exactly FRAME_CYCLES with no gap clocks.
- enable deasserted mid-frame: the current pulse and the frame both complete, with no truncated pulse. Then the block goes to IDLE with pwm_out = 0.
- enable reasserted during the LOW tail of the same frame: treated as continuous operation, so the next frame starts on schedule.
- frame_start is high for exactly one clock, coincident with the first pwm_out=1 clock. It is never asserted in IDLE.
- Static parameter constraints:
  - DUTY_MIN >= 1.
  - DUTY_MIN <= DUTY_RESET <= DUTY_MAX.
  - DUTY_MAX*TICK_CYCLES < FRAME_CYCLES.
  - A violation raises an elaboration-time error.

Decomposition:
- Shared package servo_pkg holds:
  - the state enum typedef (IDLE, HIGH, LOW);
  - default constants for FRAME_CYCLES, TICK_CYCLES, DUTY_MIN, DUTY_MAX and DUTY_RESET;
  - a clamp_duty function that returns the clamped duty and the clamp flag.
- No sub-module. The block is a single FSM plus one counter and one multiply-by-constant.

Test Plan:
- Reset, enable=1, duty=150 -> frame_start one clock after enable, then every 240000 clocks. pwm_out high for 18000 clocks, low for 222000. clamped=0, duty_latched=150.
- duty=90 -> duty_latched=100, high 12000 clocks, clamped=1. duty=250 -> duty_latched=200, high 24000 clocks, clamped=1. duty=100 and duty=200 -> clamped=0.
- duty changes 150->180 at frame_ctr=5000 -> current frame high 18000 clocks, next frame high 21600 clocks, with duty_latched switching at that frame's frame_start.
- enable drops at frame_ctr=1000 -> pulse still 18000 clocks, pwm_out stays 0 to frame end, then IDLE with no frame_start. Re-enable -> frame_start and pwm_out=1 one clock later.
- reset asserted at frame_ctr=9000 during HIGH -> pwm_out=0 in the same cycle (asynchronous), duty_latched=150, state IDLE. Release with enable=1 -> new frame starts on the following clock with a full 18000-clock pulse (duty=150).

Source files
------------

// File: rtl/servo_pwm_gen_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : servo_pkg
//  Description : Shared state encoding, default timing constants and the
//                duty clamp helper for the servo PWM generator.
//  Revision    : 1.0
// ============================================================================
package servo_pkg;

    localparam int unsigned FRAME_CYCLES_DEF = 240000;
    localparam int unsigned TICK_CYCLES_DEF  = 120;
    localparam logic [7:0]  DUTY_MIN_DEF     = 8'd100;
    localparam logic [7:0]  DUTY_MAX_DEF     = 8'd200;
    localparam logic [7:0]  DUTY_RESET_DEF   = 8'd150;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    typedef struct packed {
        logic [7:0] duty;
        logic       clamped;
    } clamp_t;

    function automatic clamp_t clamp_duty(input logic [7:0] duty,
                                          input logic [7:0] lo,
                                          input logic [7:0] hi);
        clamp_t r;
        r.duty    = duty;
        r.clamped = 1'b0;
        if (duty < lo) begin
            r.duty    = lo;
            r.clamped = 1'b1;
        end else if (duty > hi) begin
            r.duty    = hi;
            r.clamped = 1'b1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/servo_pwm_gen_if.sv
`default_nettype none
// ============================================================================
//  Module      : servo_pwm_gen_if
//  Description : Control and status bundle of the servo PWM generator.
//  Revision    : 1.0
// ============================================================================
interface servo_pwm_gen_if;
    logic       enable;
    logic [7:0] duty;
    logic       pwm_out;
    logic       frame_start;
    logic [7:0] duty_latched;
    logic       clamped;

    modport master (
        output enable, duty,
        input  pwm_out, frame_start, duty_latched, clamped
    );

    modport slave (
        input  enable, duty,
        output pwm_out, frame_start, duty_latched, clamped
    );
endinterface
`default_nettype wire

// File: rtl/servo_pwm_gen.sv
`default_nettype none
// ============================================================================
//  Module      : servo_pwm_gen
//  Description : 50 Hz servo PWM generator; duty clamped and latched only at
//                frame boundaries so pulses are never runt or stretched.
//  Revision    : 1.0
// ============================================================================
module servo_pwm_gen
    import servo_pkg::*;
#(
    parameter int unsigned FRAME_CYCLES = FRAME_CYCLES_DEF,
    parameter int unsigned TICK_CYCLES  = TICK_CYCLES_DEF,
    parameter logic [7:0]  DUTY_MIN     = DUTY_MIN_DEF,
    parameter logic [7:0]  DUTY_MAX     = DUTY_MAX_DEF,
    parameter logic [7:0]  DUTY_RESET   = DUTY_RESET_DEF
) (
    input  wire             clk_12mhz,
    input  wire             reset,
    servo_pwm_gen_if.slave  bus
);

    localparam logic [17:0] TICK_W     = 18'(TICK_CYCLES);
    localparam logic [17:0] FRAME_LAST = 18'(FRAME_CYCLES - 1);

    generate
        if ((DUTY_MIN < 8'd1) || (DUTY_RESET < DUTY_MIN) || (DUTY_RESET > DUTY_MAX) ||
            (int'(DUTY_MAX) * int'(TICK_CYCLES) >= int'(FRAME_CYCLES))) begin : g_bad_params
            $error("servo_pwm_gen: illegal duty/timing parameter combination");
        end
    endgenerate

    state_t      state_q, state_d;
    logic [17:0] frame_ctr_q, frame_ctr_d;
    logic [7:0]  duty_latched_q, duty_latched_d;
    logic        clamped_q, clamped_d;
    logic        pwm_out_q, pwm_out_d;
    logic        frame_start_q, frame_start_d;

    logic [17:0] w_high_last;
    logic        w_start;
    clamp_t      w_clamp;

    // Last HIGH count; duty_latched_q already holds this frame's value while in HIGH.
    assign w_high_last = ({10'd0, duty_latched_q} * TICK_W) - 18'd1;
    assign w_clamp     = clamp_duty(bus.duty, DUTY_MIN, DUTY_MAX);

    always_comb begin
        state_d        = state_q;
        frame_ctr_d    = frame_ctr_q + 18'd1;
        duty_latched_d = duty_latched_q;
        clamped_d      = clamped_q;
        w_start        = 1'b0;

        case (state_q)
            IDLE: begin
                frame_ctr_d = 18'd0;
                w_start     = bus.enable;
            end
            HIGH: begin
                if (frame_ctr_q == w_high_last) state_d = LOW;
            end
            LOW: begin
                if (frame_ctr_q == FRAME_LAST) begin
                    w_start     = bus.enable;
                    state_d     = IDLE;
                    frame_ctr_d = 18'd0;
                end
            end
            default: begin
                state_d     = IDLE;
                frame_ctr_d = 18'd0;
            end
        endcase

        if (w_start) begin
            state_d        = HIGH;
            frame_ctr_d    = 18'd0;
            duty_latched_d = w_clamp.duty;
            clamped_d      = w_clamp.clamped;
        end

        pwm_out_d     = (state_d == HIGH);
        frame_start_d = w_start;
    end

    always_ff @(posedge clk_12mhz or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            frame_ctr_q    <= 18'd0;
            duty_latched_q <= DUTY_RESET;
            clamped_q      <= 1'b0;
            pwm_out_q      <= 1'b0;
            frame_start_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            frame_ctr_q    <= frame_ctr_d;
            duty_latched_q <= duty_latched_d;
            clamped_q      <= clamped_d;
            pwm_out_q      <= pwm_out_d;
            frame_start_q  <= frame_start_d;
        end
    end

    assign bus.pwm_out      = pwm_out_q;
    assign bus.frame_start  = frame_start_q;
    assign bus.duty_latched = duty_latched_q;
    assign bus.clamped      = clamped_q;

endmodule
`default_nettype wire

// File: tb/tb_servo_pwm_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_servo_pwm_gen
//  Description : Directed self-checking bench for servo_pwm_gen using a
//                shortened frame (1000 clocks, 4 clocks per duty LSB).
//  Revision    : 1.0
// ============================================================================
module tb_servo_pwm_gen;

    localparam int FRAME = 1000;
    localparam int TICK  = 4;
    localparam int LIM   = 2 * FRAME + 10;

    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;

    servo_pwm_gen_if bus ();

    servo_pwm_gen #(
        .FRAME_CYCLES (FRAME),
        .TICK_CYCLES  (TICK),
        .DUTY_MIN     (8'd100),
        .DUTY_MAX     (8'd200),
        .DUTY_RESET   (8'd150)
    ) dut (
        .clk_12mhz (clk),
        .reset     (rst),
        .bus       (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts consecutive high samples starting at the current negedge.
    task automatic count_high(output int n, output int fs);
        n  = 0;
        fs = 0;
        while (bus.pwm_out === 1'b1 && n < LIM) begin
            if (bus.frame_start === 1'b1) fs++;
            n++;
            @(negedge clk);
        end
    endtask

    // Counts low samples until the next frame_start (or the bound runs out).
    task automatic count_low(output int n, output bit got);
        n   = 0;
        got = 1'b0;
        while (n < LIM) begin
            if (bus.frame_start === 1'b1) begin
                got = 1'b1;
                break;
            end
            n++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        int fs_seen;
        int hi_seen;
        rst        = 1'b1;
        bus.enable = 1'b0;
        bus.duty   = 8'd150;
        repeat (3) @(negedge clk);
        tests_run++;
        if (bus.pwm_out !== 1'b0 || bus.frame_start !== 1'b0 || bus.clamped !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_outputs: pwm=%b fs=%b clamped=%b required 0 0 0",
                     bus.pwm_out, bus.frame_start, bus.clamped);
        end
        tests_run++;
        if (bus.duty_latched !== 8'd150) begin
            tests_failed++;
            $display("FAIL reset_duty: got %0d required 150", bus.duty_latched);
        end
        rst     = 1'b0;
        fs_seen = 0;
        hi_seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.frame_start !== 1'b0) fs_seen++;
            if (bus.pwm_out !== 1'b0) hi_seen++;
        end
        tests_run++;
        if (fs_seen != 0 || hi_seen != 0) begin
            tests_failed++;
            $display("FAIL idle_quiet: frame_start=%0d pwm_high=%0d required 0 0", fs_seen, hi_seen);
        end
    endtask

    task automatic test_nominal();
        int n, fs;
        bit got;
        bus.duty   = 8'd150;
        bus.enable = 1'b1;
        @(negedge clk);
        tests_run++;
        if (bus.frame_start !== 1'b1 || bus.pwm_out !== 1'b1) begin
            tests_failed++;
            $display("FAIL start_latency: fs=%b pwm=%b required 1 1", bus.frame_start, bus.pwm_out);
        end
        tests_run++;
        if (bus.duty_latched !== 8'd150 || bus.clamped !== 1'b0) begin
            tests_failed++;
            $display("FAIL nominal_latch: duty=%0d clamped=%b required 150 0",
                     bus.duty_latched, bus.clamped);
        end
        for (int f = 0; f < 2; f++) begin
            count_high(n, fs);
            tests_run++;
            if (n != 600 || fs != 1) begin
                tests_failed++;
                $display("FAIL nominal_high[%0d]: high=%0d fs=%0d required 600 1", f, n, fs);
            end
            count_low(n, got);
            tests_run++;
            if (!got || n != 400) begin
                tests_failed++;
                $display("FAIL nominal_low[%0d]: low=%0d next_start=%b required 400 1", f, n, got);
            end
        end
    endtask

    task automatic test_clamp();
        logic [7:0] d_in [4]  = '{8'd90, 8'd250, 8'd100, 8'd200};
        logic [7:0] d_exp [4] = '{8'd100, 8'd200, 8'd100, 8'd200};
        logic       c_exp [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        int         h_exp [4] = '{400, 800, 400, 800};
        int n, fs;
        bit got;
        for (int i = 0; i < 4; i++) begin
            bus.duty = d_in[i];
            count_high(n, fs);
            count_low(n, got);
            tests_run++;
            if (!got || bus.duty_latched !== d_exp[i] || bus.clamped !== c_exp[i]) begin
                tests_failed++;
                $display("FAIL clamp_latch[%0d]: start=%b duty=%0d clamped=%b required 1 %0d %b",
                         i, got, bus.duty_latched, bus.clamped, d_exp[i], c_exp[i]);
            end
            count_high(n, fs);
            tests_run++;
            if (n != h_exp[i]) begin
                tests_failed++;
                $display("FAIL clamp_high[%0d]: high=%0d required %0d", i, n, h_exp[i]);
            end
            count_low(n, got);
        end
    endtask

    task automatic test_mid_frame_change();
        int n, fs;
        bit got;
        bus.duty = 8'd150;
        count_high(n, fs);
        count_low(n, got);
        n = 0;
        while (bus.pwm_out === 1'b1 && n < LIM) begin
            if (n == 200) bus.duty = 8'd180;
            n++;
            @(negedge clk);
        end
        tests_run++;
        if (n != 600 || bus.duty_latched !== 8'd150) begin
            tests_failed++;
            $display("FAIL midchange_current: high=%0d duty=%0d required 600 150", n, bus.duty_latched);
        end
        count_low(n, got);
        tests_run++;
        if (!got || bus.duty_latched !== 8'd180) begin
            tests_failed++;
            $display("FAIL midchange_latch: start=%b duty=%0d required 1 180", got, bus.duty_latched);
        end
        count_high(n, fs);
        tests_run++;
        if (n != 720) begin
            tests_failed++;
            $display("FAIL midchange_next: high=%0d required 720", n);
        end
        bus.duty = 8'd150;
        count_low(n, got);
    endtask

    task automatic test_enable_drop();
        int n, fs_seen, hi_seen;
        n = 0;
        while (bus.pwm_out === 1'b1 && n < LIM) begin
            if (n == 100) bus.enable = 1'b0;
            n++;
            @(negedge clk);
        end
        tests_run++;
        if (n != 600) begin
            tests_failed++;
            $display("FAIL drop_pulse: high=%0d required 600", n);
        end
        fs_seen = 0;
        hi_seen = 0;
        repeat (1500) begin
            if (bus.frame_start !== 1'b0) fs_seen++;
            if (bus.pwm_out !== 1'b0) hi_seen++;
            @(negedge clk);
        end
        tests_run++;
        if (fs_seen != 0 || hi_seen != 0) begin
            tests_failed++;
            $display("FAIL drop_idle: frame_start=%0d pwm_high=%0d required 0 0", fs_seen, hi_seen);
        end
        bus.enable = 1'b1;
        @(negedge clk);
        tests_run++;
        if (bus.frame_start !== 1'b1 || bus.pwm_out !== 1'b1) begin
            tests_failed++;
            $display("FAIL reenable: fs=%b pwm=%b required 1 1", bus.frame_start, bus.pwm_out);
        end
    endtask

    task automatic test_tail_reenable();
        int n;
        bit got;
        n = 0;
        while (bus.pwm_out === 1'b1 && n < LIM) begin
            if (n == 100) bus.enable = 1'b0;
            n++;
            @(negedge clk);
        end
        n   = 0;
        got = 1'b0;
        while (n < LIM) begin
            if (bus.frame_start === 1'b1) begin
                got = 1'b1;
                break;
            end
            if (n == 50) bus.enable = 1'b1;
            n++;
            @(negedge clk);
        end
        tests_run++;
        if (!got || n != 400) begin
            tests_failed++;
            $display("FAIL tail_reenable: low=%0d next_start=%b required 400 1", n, got);
        end
    endtask

    task automatic test_reset_mid_pulse();
        int n, fs;
        bit got;
        bus.duty = 8'd180;
        count_high(n, fs);
        count_low(n, got);
        repeat (300) @(negedge clk);
        rst = 1'b1;
        #1;
        tests_run++;
        if (bus.pwm_out !== 1'b0 || bus.frame_start !== 1'b0 ||
            bus.duty_latched !== 8'd150 || bus.clamped !== 1'b0) begin
            tests_failed++;
            $display("FAIL async_reset: pwm=%b fs=%b duty=%0d clamped=%b required 0 0 150 0",
                     bus.pwm_out, bus.frame_start, bus.duty_latched, bus.clamped);
        end
        bus.duty = 8'd150;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        tests_run++;
        if (bus.frame_start !== 1'b1 || bus.pwm_out !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_restart: fs=%b pwm=%b required 1 1", bus.frame_start, bus.pwm_out);
        end
        count_high(n, fs);
        tests_run++;
        if (n != 600 || fs != 1) begin
            tests_failed++;
            $display("FAIL reset_restart_high: high=%0d fs=%0d required 600 1", n, fs);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        bus.enable   = 1'b0;
        bus.duty     = 8'd150;
        test_reset();
        test_nominal();
        test_clamp();
        test_mid_frame_change();
        test_enable_drop();
        test_tail_reenable();
        test_reset_mid_pulse();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
